// File: rtl/imem_loader_pkg.sv
// Shared encodings for the instruction-memory loader and its neighbours
// (datapath bench, future data-memory loader).
package imem_loader_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and datapath hold of the loader.
// Handshake: a byte moves on a rising edge only when byte_valid and byte_ready are both high.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  import imem_loader_pkg::*;

  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic [ADDR_W-2:0] word_count;
  state_t            dbg_state;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, word_count, dbg_state
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, word_count, dbg_state
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Collects four bytes into a 32-bit word; byte order selected by BIG_ENDIAN.
module imem_loader_byte_packer #(
  parameter int BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= 2'd0;
      word <= 32'h0;
    end else if (clear) begin
      idx  <= 2'd0;
      word <= 32'h0;
    end else if (load) begin
      idx <= idx + 2'd1;
      // Shifting in from the side opposite the first byte leaves it at [31:24] or [7:0].
      if (BIG_ENDIAN != 0) word <= {word[23:0], data};
      else                 word <= {data, word[31:8]};
    end
  end

  // High when the current load completes the word.
  assign word_full = load && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Run-time instruction-memory loader: packs a byte stream into words, writes them
// at incrementing addresses and holds the datapath until the session completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int NUM_WORDS  = 16,
  parameter int BASE_ADDR  = 0,
  parameter int BIG_ENDIAN = 1
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-2:0] LAST_CNT  = (ADDR_W-1)'(NUM_WORDS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-2:0] wcount;
  logic [31:0]       wdata_hold;
  logic              pk_clear, pk_load, pk_full;
  logic [31:0]       pk_word;
  logic              start_ok;

  assign start_ok = ((state == IDLE) || (state == DONE)) && bus.start;

  imem_loader_byte_packer #(.BIG_ENDIAN(BIG_ENDIAN)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .load      (pk_load),
    .data      (bus.byte_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_nxt = state;
    pk_clear  = 1'b0;
    pk_load   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = RECV;
          pk_clear  = 1'b1;
        end
      end
      RECV: begin
        if (bus.byte_valid) begin
          pk_load = 1'b1;
          if (pk_full) state_nxt = WRITE;
        end
      end
      WRITE: state_nxt = (wcount == LAST_CNT) ? DONE : RECV;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= BASE;
      wcount     <= '0;
      wdata_hold <= 32'h0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        addr   <= BASE;
        wcount <= '0;
      end else if (state == WRITE) begin
        addr       <= addr + ADDR_STEP;
        wcount     <= wcount + 1'b1;
        wdata_hold <= pk_word;
      end
    end
  end

  // Outside WRITE the data bus shows the last word written; the memory qualifies on mem_we.
  assign bus.mem_wdata  = (state == WRITE) ? pk_word : wdata_hold;
  assign bus.byte_ready = (state == RECV);
  assign bus.mem_we     = (state == WRITE);
  assign bus.mem_addr   = addr;
  assign bus.cpu_hold   = (state != DONE);
  assign bus.done       = (state == DONE);
  assign bus.word_count = wcount;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: three configurations (big-endian, little-endian with
// address wrap, narrow 4-bit address with wrap) driven in lockstep.
module tb_imem_loader;
  import imem_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start;
  logic       byte_valid;
  logic [7:0] byte_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [39:0] exp_a_q[$];
  logic [39:0] exp_b_q[$];
  logic [39:0] exp_c_q[$];
  logic [7:0]  sess_bytes[8];
  bit          stall_pat[7] = '{1, 0, 0, 1, 1, 0, 1};
  int          pat_idx = 0;

  imem_loader_if #(.ADDR_W(8)) ifa ();
  imem_loader_if #(.ADDR_W(8)) ifb ();
  imem_loader_if #(.ADDR_W(4)) ifc ();

  assign ifa.start = start;  assign ifa.byte_valid = byte_valid;  assign ifa.byte_data = byte_data;
  assign ifb.start = start;  assign ifb.byte_valid = byte_valid;  assign ifb.byte_data = byte_data;
  assign ifc.start = start;  assign ifc.byte_valid = byte_valid;  assign ifc.byte_data = byte_data;

  imem_loader #(.ADDR_W(8), .NUM_WORDS(2), .BASE_ADDR(0),   .BIG_ENDIAN(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  imem_loader #(.ADDR_W(8), .NUM_WORDS(2), .BASE_ADDR(252), .BIG_ENDIAN(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  imem_loader #(.ADDR_W(4), .NUM_WORDS(2), .BASE_ADDR(12),  .BIG_ENDIAN(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] pack_word(input logic [7:0] b0, b1, b2, b3, input bit be);
    return be ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
  endfunction

  task automatic push_expected();
    for (int w = 0; w < 2; w++) begin
      exp_a_q.push_back({8'((0 + 4 * w) % 256),
        pack_word(sess_bytes[4*w], sess_bytes[4*w+1], sess_bytes[4*w+2], sess_bytes[4*w+3], 1'b1)});
      exp_b_q.push_back({8'((252 + 4 * w) % 256),
        pack_word(sess_bytes[4*w], sess_bytes[4*w+1], sess_bytes[4*w+2], sess_bytes[4*w+3], 1'b0)});
      exp_c_q.push_back({8'((12 + 4 * w) % 16),
        pack_word(sess_bytes[4*w], sess_bytes[4*w+1], sess_bytes[4*w+2], sess_bytes[4*w+3], 1'b1)});
    end
  endtask

  // ---------------- scoreboard: every strobe must match the next expected write ----------------
  always @(negedge clk) begin
    if (ifa.mem_we === 1'b1) begin
      if (exp_a_q.size() == 0) check_val("a_unexpected_we", 1, 0);
      else check_val("a_write", {ifa.mem_addr, ifa.mem_wdata}, exp_a_q.pop_front());
    end
    if (ifb.mem_we === 1'b1) begin
      if (exp_b_q.size() == 0) check_val("b_unexpected_we", 1, 0);
      else check_val("b_write", {ifb.mem_addr, ifb.mem_wdata}, exp_b_q.pop_front());
    end
    if (ifc.mem_we === 1'b1) begin
      if (exp_c_q.size() == 0) check_val("c_unexpected_we", 1, 0);
      else check_val("c_write", {4'h0, ifc.mem_addr, ifc.mem_wdata}, exp_c_q.pop_front());
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  // mode 0: valid held high; 1: random valid; 2: fixed stall pattern
  task automatic send_byte(input logic [7:0] b, input int mode, input bit inject_start);
    bit accepted = 0;
    int guard = 0;
    byte_data = b;
    while (!accepted && guard < 64) begin
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = 1'($urandom_range(0, 1));
        default: begin byte_valid = stall_pat[pat_idx % 7]; pat_idx++; end
      endcase
      start = inject_start && ($urandom_range(0, 2) == 0);
      accepted = byte_valid && ifa.byte_ready;
      @(posedge clk); #1;
      start      = 1'b0;
      byte_valid = 1'b0;
      guard++;
    end
    if (!accepted) check_val("byte_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    push_expected();
    @(posedge clk); #1 start = 1'b0;
    check_val("start_cpu_hold",   ifa.cpu_hold,   1);
    check_val("start_done",       ifa.done,       0);
    check_val("start_word_count", ifa.word_count, 0);
    check_val("start_byte_ready", ifa.byte_ready, 1);
    check_val("start_addr_a",     ifa.mem_addr,   0);
    check_val("start_addr_b",     ifb.mem_addr,   252);
    check_val("start_addr_c",     ifc.mem_addr,   12);
  endtask

  task automatic run_session(input int mode, input bit inject_start);
    pulse_start();
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 4; k++) send_byte(sess_bytes[4*w+k], mode, inject_start);
      check_val("we_after_4th_byte", ifa.mem_we,     1);
      check_val("ready_low_in_we",   ifa.byte_ready, 0);
      check_val("word_count_in_we",  ifa.word_count, w);
    end
    @(posedge clk); #1;
    check_val("end_done",       ifa.done,       1);
    check_val("end_cpu_hold",   ifa.cpu_hold,   0);
    check_val("end_word_count", ifa.word_count, 2);
    check_val("end_byte_ready", ifa.byte_ready, 0);
    check_val("end_addr_a",     ifa.mem_addr,   8);
    check_val("end_addr_b",     ifb.mem_addr,   4);
    check_val("end_addr_c",     ifc.mem_addr,   4);
  endtask

  task automatic random_bytes();
    for (int i = 0; i < 8; i++) sess_bytes[i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_byte_ready", ifa.byte_ready, 0);
    check_val("rst_mem_we",     ifa.mem_we,     0);
    check_val("rst_addr_a",     ifa.mem_addr,   0);
    check_val("rst_addr_b",     ifb.mem_addr,   252);
    check_val("rst_addr_c",     ifc.mem_addr,   12);
    check_val("rst_wdata",      ifa.mem_wdata,  0);
    check_val("rst_cpu_hold",   ifa.cpu_hold,   1);
    check_val("rst_done",       ifa.done,       0);
    check_val("rst_word_count", ifa.word_count, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_val("hold_after_rst", ifa.cpu_hold, 1);

    // Basic load with a known program
    sess_bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    run_session(0, 1'b0);

    // Stalled source; the restart from DONE is exercised here too
    random_bytes();
    run_session(2, 1'b0);

    // Reset after two bytes of the first word
    random_bytes();
    pulse_start();
    send_byte(sess_bytes[0], 0, 1'b0);
    send_byte(sess_bytes[1], 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_cpu_hold",   ifa.cpu_hold,   1);
    check_val("midrst_done",       ifa.done,       0);
    check_val("midrst_mem_we",     ifa.mem_we,     0);
    check_val("midrst_byte_ready", ifa.byte_ready, 0);
    check_val("midrst_addr_c",     ifc.mem_addr,   12);
    exp_a_q.delete(); exp_b_q.delete(); exp_c_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    random_bytes();
    run_session(0, 1'b0);

    // Random traffic with stray start pulses during RECV/WRITE
    for (int s = 0; s < 6; s++) begin
      random_bytes();
      run_session(1, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    check_val("a_exp_drained", exp_a_q.size(), 0);
    check_val("b_exp_drained", exp_b_q.size(), 0);
    check_val("c_exp_drained", exp_c_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writes a program image into the datapath's instruction memory at run time, replacing file preload for in-system loading.
- The datapath's fetch path is the reader of instruction memory; this block is the writer.
- Accepts a byte stream over a valid/ready handshake, packs four bytes per 32-bit instruction word, and issues one write strobe per word at incrementing byte addresses.
- Holds the datapath (cpu_hold) until the programmed word count has been written.

Parameters:
- ADDR_W, 8: instruction memory byte-address width.
- NUM_WORDS, 16: words to load per session, 1..2^(ADDR_W-2).
- BASE_ADDR, 0: first byte address written; must be a multiple of 4.
- BIG_ENDIAN, 1: 1 = first received byte goes to bits [31:24]; 0 = first byte goes to bits [7:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session; sampled only in IDLE or DONE.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  incoming program byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  ADDR_W  byte address of the word being written.
- mem_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  datapath must not fetch or commit while high.
- done  output  1  high after a session completes, until the next start or reset.
- word_count  output  ADDR_W-1  words written in the current session.

Behaviour:
- Reset (async assert, sync release): state=IDLE, byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, word_count=0, byte index=0.
- After reset the datapath stays held until the first session completes.
- States:
  - IDLE: byte_ready=0. start -> RECV; clears word_count, byte index and done; sets mem_addr=BASE_ADDR; cpu_hold=1.
  - RECV: byte_ready=1. A byte is taken only when byte_valid and byte_ready are both high on a rising edge. The byte shifts into the word per BIG_ENDIAN and byte index increments. When the 4th byte is taken -> WRITE.
  - WRITE: exactly one cycle. mem_we=1, mem_wdata=the full word, mem_addr=current address, byte_ready=0. The next edge increments word_count and adds 4 to mem_addr (modulo 2^ADDR_W). If word_count+1 == NUM_WORDS -> DONE; otherwise -> RECV.
  - DONE: byte_ready=0, cpu_hold=0, done=1. start -> RECV, with the same clears as IDLE->RECV, and cpu_hold rises on the next edge.
- Per-word latency: the write strobe appears the cycle after the 4th byte handshake, so there is one bubble cycle per word.
- Throughput: 4 bytes per 5 cycles maximum.
- byte_valid may drop mid-word. The partial word and byte index are retained indefinitely, with no timeout.
- start while in RECV or WRITE is ignored; it does not restart the session.
- byte_valid while byte_ready=0 is ignored; that byte is not consumed.
- Address wrap: mem_addr wraps past 2^ADDR_W-4 to 0. The block does not flag wrap; configuring NUM_WORDS too large is a user error.
- Reset mid-session discards the partial word and returns to reset values. No write strobe is emitted during or after the reset edge.
- mem_wdata keeps its last written value outside WRITE. The memory must qualify writes with mem_we only.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3) and WORD_BYTES=4, so the datapath bench and a future data-memory loader use the same values.
- One natural sub-module: byte_packer. It holds the 2-bit byte index and the 32-bit shift/insert register with BIG_ENDIAN selection, plus load/clear inputs and a word_full output.
- The FSM, address counter and word counter stay in imem_loader.

Test Plan:
- Basic load, NUM_WORDS=2, BIG_ENDIAN=1, BASE_ADDR=0:
  - Stimulus: start, then bytes 20,08,00,05,20,09,00,07 (hex) with byte_valid held high.
  - Required: mem_we pulses twice, writing 32'h20080005 at addr 0 and 32'h20090007 at addr 4.
  - Then done=1 and cpu_hold=0 one cycle after the second strobe; word_count=2.
- Little-endian: BIG_ENDIAN=0, bytes 05,00,08,20 -> mem_wdata=32'h20080005.
- Stalled source: byte_valid toggles 1,0,0,1,1,0,1 across a word.
  - Required: only valid&ready bytes are consumed, the word is correct, and exactly one mem_we occurs.
- Reset mid-word: assert rst after 2 of 4 bytes.
  - Required: outputs go to reset values immediately (cpu_hold=1, done=0) and no mem_we is emitted.
  - A fresh start plus 4 bytes writes a complete word at BASE_ADDR.
- Restart and ignore rules:
  - start pulsed during RECV has no effect.
  - start in DONE raises cpu_hold, clears done and word_count, and reloads at BASE_ADDR.
- Address wrap: ADDR_W=4, BASE_ADDR=12, NUM_WORDS=2 -> writes at addr 12 then addr 0.
